if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stall  input  1  downstream stall; high holds the presented instruction.
REQ-005 id_if_pce  input  1  redirect strobe from decode.
REQ-006 id_if_pc  input  32  redirect offset from decode.
REQ-007 id_if_off  input  32  redirect base from decode.
REQ-008 mem_gnt  input  1  memory arbiter grant for the current request cycle.
REQ-009 mem_din  input  8  read byte, valid the cycle after a granted request.
REQ-010 mem_rd  output  1  byte read request.
REQ-011 mem_a  output  32  byte read address.
REQ-012 pc  output  32  fetch address of the presented instruction plus 4.
REQ-013 is  output  32  presented instruction word; 32'h0 when no instruction is valid (bubble).

Function
REQ-014 FSM states: IDLE, REQ0, REQ1, REQ2, REQ3, WAIT3, HOLD.
REQ-015 REQn shall drive mem_rd=1 and mem_a=fa+n, where fa is the fetch address register; it advances only when mem_gnt=1, otherwise it stays in REQn.
REQ-016 The byte for a granted request shall be captured from mem_din on the following cycle into byte lane n (little-endian, bits 8n+7:8n); WAIT3 shall capture lane 3.
REQ-017 Capture of lanes 0..2 shall overlap the next request, so an uncontended fetch takes 5 cycles from REQ0 entry to HOLD entry.
REQ-018 On WAIT3 exit the module shall enter HOLD, driving is=assembled word and pc=fa+4 for one cycle.
REQ-019 In HOLD with stall=0, fa shall become fa+4 and the FSM shall enter REQ0 next cycle; with stall=1 it shall remain in HOLD with pc/is unchanged.
REQ-020 Outside HOLD, is shall be 32'h0 and pc shall keep its last value.
REQ-021 Redirect: id_if_pce=1 in any state shall set fa to id_if_off+id_if_pc (32-bit, wrap-around, no carry-out), discard partially assembled bytes, drop the in-flight capture, force is=32'h0 in the next cycle, and enter REQ0.
REQ-022 Redirect shall take priority over stall and over normal HOLD advance in the same cycle.
REQ-023 mem_rd shall be 0 in IDLE, WAIT3 and HOLD.
REQ-024 fa+4 and fa+n shall wrap modulo 2^32.

Reset
REQ-025 With rst=1 at a clock edge: state=IDLE, fa=RESET_PC, pc=32'h0, is=32'h0, mem_rd=0, mem_a=32'h0, byte lanes cleared.
REQ-026 The cycle after rst deasserts shall leave IDLE for REQ0; rst mid-fetch shall abort with no partial word ever presented.

Configuration
REQ-027 Macro IF_PREFETCH_EN: when defined, a one-word prefetch buffer shall let the next sequential fetch (fa+4) proceed while HOLD is stalled; on stall release the buffered word is presented the next cycle (1-cycle HOLD-to-HOLD); a redirect invalidates the buffer.
REQ-028 Without IF_PREFETCH_EN, no fetch shall be issued while in HOLD.

Structure
REQ-029 A shared package shall hold the state encoding, the bubble constant 32'h0 and the RESET_PC default.
REQ-030 Prefetch buffer (IF_PREFETCH_EN only) shall be a sub-module if_pfbuf: a one-entry valid/data register with load, take and flush.

Verification
REQ-031 Reset, mem_gnt=1, memory bytes 13,05,10,00 at 0..3 -> mem_a 0,1,2,3; HOLD on cycle 5 with is=32'h00100513, pc=32'h4.
REQ-032 mem_gnt low 3 cycles during REQ1 -> mem_a holds 1, mem_rd stays 1, word correct, HOLD delayed by exactly 3 cycles.
REQ-033 stall=1 for 4 cycles in HOLD -> is/pc constant, mem_rd=0 (without IF_PREFETCH_EN); release -> mem_a=4 next cycle.
REQ-034 id_if_pce=1, id_if_off=32'h100, id_if_pc=32'hFFFF_FFF8 during REQ2 -> next cycle REQ0 with mem_a=32'hF8, is=0; the old partial word is never presented.
REQ-035 id_if_pce and stall both high in HOLD -> redirect wins, is=0 next cycle.
REQ-036 fa=32'hFFFF_FFFC -> mem_a FFFF_FFFC..FFFF_FFFF, pc=32'h0 (wrap).

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the byte-serial instruction fetch unit.
// State encoding, bubble constant, reset PC default and request-lane helper.
package if_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        REQ1  = 3'd2,
        REQ2  = 3'd3,
        REQ3  = 3'd4,
        WAIT3 = 3'd5,
        HOLD  = 3'd6
    } state_t;

    localparam logic [31:0] BUBBLE       = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // Byte lane requested by a REQn state; other states never issue requests.
    function automatic logic [1:0] req_lane(input state_t s);
        case (s)
            REQ1:    return 2'd1;
            REQ2:    return 2'd2;
            REQ3:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/if_pfbuf.sv
// One-entry prefetch buffer (built only with IF_PREFETCH_EN): holds {pc, word} of a fetch completed under stall.
// Latency: load visible next cycle. Backpressure: flush beats load beats take; caller never loads while full.
// Holds its entry until taken or flushed.
`ifdef IF_PREFETCH_EN
module if_pfbuf (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_take,
    input  logic        i_flush,
    input  logic [63:0] i_dat,
    output logic        o_vld,
    output logic [63:0] o_dat
);

    logic        r_vld;
    logic [63:0] r_dat;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_vld <= 1'b0;
            r_dat <= 64'h0;
        end else if (i_load) begin
            r_vld <= 1'b1;
            r_dat <= i_dat;
        end else if (i_take) begin
            r_vld <= 1'b0;
        end
    end

    assign o_vld = r_vld;
    assign o_dat = r_dat;

endmodule
`endif

// File: rtl/if_fetch.sv
// Instruction fetch: assembles a 32-bit word from four byte reads and presents it in HOLD (macro IF_PREFETCH_EN adds a prefetch buffer).
// Latency: 5 cycles REQ0->HOLD with continuous grant; each denied grant adds one cycle.
// Backpressure: stall freezes HOLD; redirect (id_if_pce) overrides everything and restarts at REQ0.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        id_if_pce,
    input  logic [31:0] id_if_pc,
    input  logic [31:0] id_if_off,
    input  logic        mem_gnt,
    input  logic [7:0]  mem_din,
    output logic        mem_rd,
    output logic [31:0] mem_a,
    output logic [31:0] pc,
    output logic [31:0] is
);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_fa, w_fa_nxt;
    logic [31:0] r_is, w_is_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [23:0] r_lanes;
    logic        r_cap_vld, w_cap_vld_nxt;
    logic [1:0]  r_cap_lane, w_cap_lane_nxt;
    logic        w_lanes_clr;
    logic [1:0]  w_lane;
    logic [31:0] w_word;

    // Lane 3 arrives during WAIT3 and goes straight into the presented word.
    assign w_word = {mem_din, r_lanes};

`ifdef IF_PREFETCH_EN
    logic        r_stalled, w_stalled_nxt;
    logic        w_pf_load, w_pf_take, w_pf_flush, w_pf_vld;
    logic [63:0] w_pf_din, w_pf_dat;

    assign w_pf_din = {r_fa + 32'd4, w_word};

    if_pfbuf u_pfbuf (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_pf_load),
        .i_take  (w_pf_take),
        .i_flush (w_pf_flush),
        .i_dat   (w_pf_din),
        .o_vld   (w_pf_vld),
        .o_dat   (w_pf_dat)
    );

    always_ff @(posedge clk) begin
        if (rst) r_stalled <= 1'b0;
        else     r_stalled <= w_stalled_nxt;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fa       <= RESET_PC;
            r_is       <= BUBBLE;
            r_pc       <= 32'h0;
            r_cap_vld  <= 1'b0;
            r_cap_lane <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_fa       <= w_fa_nxt;
            r_is       <= w_is_nxt;
            r_pc       <= w_pc_nxt;
            r_cap_vld  <= w_cap_vld_nxt;
            r_cap_lane <= w_cap_lane_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_lanes_clr) begin
            r_lanes <= 24'h0;
        end else if (r_cap_vld) begin
            case (r_cap_lane)
                2'd0:    r_lanes[7:0]   <= mem_din;
                2'd1:    r_lanes[15:8]  <= mem_din;
                2'd2:    r_lanes[23:16] <= mem_din;
                default: r_lanes        <= r_lanes;
            endcase
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_fa_nxt       = r_fa;
        w_is_nxt       = r_is;
        w_pc_nxt       = r_pc;
        w_cap_vld_nxt  = 1'b0;
        w_cap_lane_nxt = 2'd0;
        w_lanes_clr    = 1'b0;
        w_lane         = req_lane(r_state);
        mem_rd         = 1'b0;
        mem_a          = 32'h0;
`ifdef IF_PREFETCH_EN
        w_pf_load      = 1'b0;
        w_pf_take      = 1'b0;
        w_pf_flush     = 1'b0;
        w_stalled_nxt  = r_stalled;
        // Held word is consumed as soon as stall drops while prefetching.
        if (r_stalled && !stall) begin
            w_is_nxt      = BUBBLE;
            w_stalled_nxt = 1'b0;
        end
`endif

        case (r_state)
            IDLE: w_state_nxt = REQ0;

            REQ0, REQ1, REQ2, REQ3: begin
                mem_rd = 1'b1;
                mem_a  = r_fa + {30'd0, w_lane};
                if (mem_gnt) begin
                    w_cap_vld_nxt  = 1'b1;
                    w_cap_lane_nxt = w_lane;
                    case (r_state)
                        REQ0:    w_state_nxt = REQ1;
                        REQ1:    w_state_nxt = REQ2;
                        REQ2:    w_state_nxt = REQ3;
                        default: w_state_nxt = WAIT3;
                    endcase
                end
            end

            WAIT3: begin
                w_state_nxt = HOLD;
`ifdef IF_PREFETCH_EN
                if (r_stalled && stall) begin
                    w_pf_load     = 1'b1;
                    w_stalled_nxt = 1'b0;
                end else
`endif
                begin
                    w_is_nxt = w_word;
                    w_pc_nxt = r_fa + 32'd4;
                end
            end

            HOLD: begin
`ifdef IF_PREFETCH_EN
                if (w_pf_vld) begin
                    if (!stall) begin
                        w_is_nxt  = w_pf_dat[31:0];
                        w_pc_nxt  = w_pf_dat[63:32];
                        w_pf_take = 1'b1;
                    end
                end else if (stall) begin
                    w_fa_nxt      = r_fa + 32'd4;
                    w_state_nxt   = REQ0;
                    w_stalled_nxt = 1'b1;
                end else
`endif
                if (!stall) begin
                    w_fa_nxt    = r_fa + 32'd4;
                    w_state_nxt = REQ0;
                    w_is_nxt    = BUBBLE;
                end
            end

            default: w_state_nxt = IDLE;
        endcase

        // Redirect beats stall, HOLD advance and any in-flight byte.
        if (id_if_pce) begin
            w_state_nxt   = REQ0;
            w_fa_nxt      = id_if_off + id_if_pc;
            w_is_nxt      = BUBBLE;
            w_cap_vld_nxt = 1'b0;
            w_lanes_clr   = 1'b1;
`ifdef IF_PREFETCH_EN
            w_pf_flush    = 1'b1;
            w_pf_load     = 1'b0;
            w_pf_take     = 1'b0;
            w_stalled_nxt = 1'b0;
`endif
        end
    end

    assign pc = r_pc;
    assign is = r_is;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: byte memory model, scoreboard of expected {is, pc}.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        id_if_pce = 1'b0;
    logic [31:0] id_if_pc = 32'h0;
    logic [31:0] id_if_off = 32'h0;
    logic        mem_gnt = 1'b1;
    logic [7:0]  mem_din = 8'h0;
    logic        mem_rd;
    logic [31:0] mem_a;
    logic [31:0] pc;
    logic [31:0] is;

    typedef struct {
        logic [31:0] is;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_pass = 0;

    if_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .id_if_pce (id_if_pce),
        .id_if_pc  (id_if_pc),
        .id_if_off (id_if_off),
        .mem_gnt   (mem_gnt),
        .mem_din   (mem_din),
        .mem_rd    (mem_rd),
        .mem_a     (mem_a),
        .pc        (pc),
        .is        (is)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h05;
            32'd2:   return 8'h10;
            32'd3:   return 8'h00;
            default: return a[7:0] ^ a[31:24] ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    // Memory returns the byte one cycle after a granted request; junk otherwise.
    always @(posedge clk) begin
        if (mem_rd && mem_gnt) mem_din <= mem_byte(mem_a);
        else                   mem_din <= 8'hEE;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_exp(input logic [31:0] fa);
        exp_t e;
        e.is = mem_word(fa);
        e.pc = fa + 32'd4;
        sb.push_back(e);
    endtask

    task automatic await_word(input int max, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < max && !ok) begin
            tick();
            cyc++;
            if (is !== 32'h0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_checks++; if (mem_rd !== 1'b0) $display("FAIL reset_mem_rd got %0b want 0", mem_rd); else n_pass++;
        n_checks++; if (mem_a !== 32'h0) $display("FAIL reset_mem_a got %h want 0", mem_a); else n_pass++;
        n_checks++; if (is !== 32'h0) $display("FAIL reset_is got %h want 0", is); else n_pass++;
        n_checks++; if (pc !== 32'h0) $display("FAIL reset_pc got %h want 0", pc); else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++; if (mem_rd !== 1'b1) $display("FAIL leave_idle mem_rd got %0b want 1", mem_rd); else n_pass++;
    endtask

    task automatic test_basic();
        int cyc; bit ok;
        push_exp(32'h0);
        for (int n = 0; n < 4; n++) begin
            n_checks++;
            if (mem_rd !== 1'b1 || mem_a !== n) $display("FAIL basic_req%0d rd=%0b a=%h want rd=1 a=%h", n, mem_rd, mem_a, n);
            else n_pass++;
            tick();
        end
        n_checks++; if (mem_rd !== 1'b0) $display("FAIL basic_wait3_rd got %0b want 0", mem_rd); else n_pass++;
        await_word(20, cyc, ok);
        cur = sb.pop_front();
        n_checks++; if (!ok || 4 + cyc != 5) $display("FAIL basic_latency got %0d want 5 (ok=%0b)", 4 + cyc, ok); else n_pass++;
        n_checks++; if (is !== cur.is || cur.is !== 32'h00100513) $display("FAIL basic_is got %h want 00100513", is); else n_pass++;
        n_checks++; if (pc !== cur.pc) $display("FAIL basic_pc got %h want %h", pc, cur.pc); else n_pass++;
    endtask

    task automatic test_gnt_wait();
        int cyc; bit ok;
        tick();
        n_checks++; if (mem_a !== 32'h4) $display("FAIL gw_req0 a=%h want 4", mem_a); else n_pass++;
        push_exp(32'h4);
        tick();
        mem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (mem_rd !== 1'b1 || mem_a !== 32'h5) $display("FAIL gw_hold%0d rd=%0b a=%h want rd=1 a=5", i, mem_rd, mem_a);
            else n_pass++;
        end
        mem_gnt = 1'b1;
        await_word(20, cyc, ok);
        cur = sb.pop_front();
        n_checks++; if (!ok || 4 + cyc != 8) $display("FAIL gw_latency got %0d want 8 (ok=%0b)", 4 + cyc, ok); else n_pass++;
        n_checks++; if (is !== cur.is || pc !== cur.pc) $display("FAIL gw_word is=%h pc=%h want is=%h pc=%h", is, pc, cur.is, cur.pc); else n_pass++;
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (is !== cur.is || pc !== cur.pc || mem_rd !== 1'b0)
                $display("FAIL stall%0d is=%h pc=%h rd=%0b want is=%h pc=%h rd=0", i, is, pc, mem_rd, cur.is, cur.pc);
            else n_pass++;
        end
        stall = 1'b0;
        tick();
        n_checks++;
        if (mem_rd !== 1'b1 || mem_a !== 32'h8 || is !== 32'h0)
            $display("FAIL stall_release rd=%0b a=%h is=%h want rd=1 a=8 is=0", mem_rd, mem_a, is);
        else n_pass++;
    endtask

    task automatic test_redirect();
        int cyc; bit ok;
        tick(); tick();
        n_checks++; if (mem_a !== 32'hA) $display("FAIL rd_req2 a=%h want a", mem_a); else n_pass++;
        id_if_pce = 1'b1; id_if_off = 32'h100; id_if_pc = 32'hFFFF_FFF8;
        tick();
        id_if_pce = 1'b0;
        n_checks++;
        if (mem_rd !== 1'b1 || mem_a !== 32'hF8 || is !== 32'h0)
            $display("FAIL redirect rd=%0b a=%h is=%h want rd=1 a=f8 is=0", mem_rd, mem_a, is);
        else n_pass++;
        push_exp(32'hF8);
        await_word(20, cyc, ok);
        cur = sb.pop_front();
        n_checks++; if (!ok || cyc != 5) $display("FAIL rd_latency got %0d want 5 (ok=%0b)", cyc, ok); else n_pass++;
        n_checks++; if (is !== cur.is || pc !== cur.pc) $display("FAIL rd_word is=%h pc=%h want is=%h pc=%h", is, pc, cur.is, cur.pc); else n_pass++;
    endtask

    task automatic test_redirect_stall();
        stall = 1'b1;
        id_if_pce = 1'b1; id_if_off = 32'h0; id_if_pc = 32'hFFFF_FFFC;
        tick();
        id_if_pce = 1'b0; stall = 1'b0;
        n_checks++;
        if (is !== 32'h0 || mem_rd !== 1'b1 || mem_a !== 32'hFFFF_FFFC)
            $display("FAIL rd_stall is=%h rd=%0b a=%h want is=0 rd=1 a=fffffffc", is, mem_rd, mem_a);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int cyc; bit ok;
        logic [31:0] base;
        base = 32'hFFFF_FFFC;
        push_exp(base);
        for (int n = 0; n < 4; n++) begin
            n_checks++;
            if (mem_a !== base + n) $display("FAIL wrap_a%0d got %h want %h", n, mem_a, base + n);
            else n_pass++;
            tick();
        end
        await_word(20, cyc, ok);
        cur = sb.pop_front();
        n_checks++; if (!ok || is !== cur.is) $display("FAIL wrap_is got %h want %h", is, cur.is); else n_pass++;
        n_checks++; if (pc !== 32'h0 || cur.pc !== 32'h0) $display("FAIL wrap_pc got %h want 0", pc); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int cyc; bit ok;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if (mem_rd !== 1'b0 || mem_a !== 32'h0 || is !== 32'h0 || pc !== 32'h0)
            $display("FAIL rst_mid rd=%0b a=%h is=%h pc=%h want all 0", mem_rd, mem_a, is, pc);
        else n_pass++;
        rst = 1'b0;
        push_exp(32'h0);
        await_word(20, cyc, ok);
        cur = sb.pop_front();
        n_checks++; if (!ok || cyc != 6) $display("FAIL rst_mid_latency got %0d want 6 (ok=%0b)", cyc, ok); else n_pass++;
        n_checks++; if (is !== cur.is || pc !== cur.pc) $display("FAIL rst_mid_word is=%h pc=%h want is=%h pc=%h", is, pc, cur.is, cur.pc); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gnt_wait();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
